// File: rtl/integration_updating_pc.sv
// PC register with +2 / return-stack next-PC select,
// a bounded LIFO return stack and a registered instruction ROM.
module integration_updating_pc #(
  parameter int RS_DEPTH   = 16,
  parameter int IMEM_WORDS = 512
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWrite,
  input  logic [2:0]  PCControl,
  input  logic [1:0]  RStackOP,
  output logic        Overflow,
  output logic [15:0] PC_out,
  output logic [15:0] inst
);

  localparam int SPW = $clog2(RS_DEPTH + 1);
  localparam int AW  = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam logic [SPW-1:0] FULL = SPW'(RS_DEPTH);

  logic [15:0]    pc;
  logic [15:0]    pc_plus2;
  logic [15:0]    next_pc;
  logic [15:0]    rs_top;
  logic [15:0]    rom_data;
  logic [15:0]    rs [RS_DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_m1;
  logic [8:0]     waddr;
  logic [8:0]     hi_idx;
  logic           push_ok;
  logic           pop_ok;

  assign {Overflow, pc_plus2} = {1'b0, pc} + 17'd2;
  assign PC_out = pc;

  assign sp_m1  = sp - SPW'(1);
  assign rs_top = (sp == '0) ? 16'h0000 : rs[sp_m1[AW-1:0]];

  assign push_ok = (RStackOP == 2'd1) && (sp != FULL);
  assign pop_ok  = (RStackOP == 2'd3) && (sp != '0);

  always_comb begin
    next_pc = pc;
    case (PCControl)
      3'd0:    next_pc = rs_top;
      3'd4:    next_pc = pc_plus2;
      default: next_pc = pc;
    endcase
  end

  // Fixed ROM image: ramp 0..11, then 0x1000..0x8000
  assign waddr  = pc[9:1];
  assign hi_idx = waddr - 9'd11;

  always_comb begin
    rom_data = 16'h0000;
    if (32'(waddr) < IMEM_WORDS) begin
      if (waddr <= 9'd11)
        rom_data = {7'b0, waddr};
      else if (waddr <= 9'd19)
        rom_data = {hi_idx[3:0], 12'h000};
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      pc   <= 16'h0000;
      inst <= 16'h0000;
      sp   <= '0;
    end else begin
      inst <= rom_data;
      if (PCWrite)
        pc <= next_pc;
      if (push_ok)
        sp <= sp + SPW'(1);
      else if (pop_ok)
        sp <= sp_m1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset && push_ok)
      rs[sp[AW-1:0]] <= pc_plus2;
  end

endmodule

// File: tb/tb_integration_updating_pc.sv
// Bench for integration_updating_pc: directed table,
// corner sequences and random traffic against a queue model.
module tb_integration_updating_pc;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        PCWrite;
  logic [2:0]  PCControl;
  logic [1:0]  RStackOP;
  logic        Overflow;
  logic [15:0] PC_out;
  logic [15:0] inst;

  int checks = 0;
  int failures = 0;

  integration_updating_pc #(.RS_DEPTH(16), .IMEM_WORDS(512)) dut (
    .CLK(CLK), .Reset(Reset), .PCWrite(PCWrite),
    .PCControl(PCControl), .RStackOP(RStackOP),
    .Overflow(Overflow), .PC_out(PC_out), .inst(inst)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  int unsigned m_pc = 0;
  int unsigned m_inst = 0;
  int unsigned m_stk[$];

  function automatic int unsigned rom(int unsigned pc);
    int unsigned w;
    w = (pc >> 1) & 511;
    if (w <= 11) return w;
    if (w <= 19) return (w - 11) * 4096;
    return 0;
  endfunction

  task automatic chk(string name, int unsigned act, int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive, advance model, compare against model
  task automatic step(input logic rst, input logic pcw,
                      input logic [2:0] ctl, input logic [1:0] op);
    int unsigned top, npc, nxt2;
    Reset = rst; PCWrite = pcw; PCControl = ctl; RStackOP = op;
    @(posedge CLK);
    if (!rst) begin
      m_pc = 0; m_inst = 0; m_stk.delete();
    end else begin
      top  = (m_stk.size() > 0) ? m_stk[$] : 0;
      nxt2 = (m_pc + 2) % 65536;
      npc  = (ctl == 0) ? top : (ctl == 4) ? nxt2 : m_pc;
      m_inst = rom(m_pc);
      if (op == 1 && m_stk.size() < 16) m_stk.push_back(nxt2);
      else if (op == 3 && m_stk.size() > 0) void'(m_stk.pop_back());
      if (pcw) m_pc = npc;
    end
    #1;
    chk("model_pc", PC_out, m_pc);
    chk("model_inst", inst, m_inst);
    chk("model_ovf", Overflow, (m_pc >= 16'hFFFE) ? 1 : 0);
  endtask

  typedef struct {
    logic        rst;
    logic        pcw;
    logic [2:0]  ctl;
    logic [1:0]  op;
    logic [15:0] e_pc;
    logic [15:0] e_inst;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic rst, logic pcw, logic [2:0] ctl,
                             logic [1:0] op, logic [15:0] ep,
                             logic [15:0] ei);
    vec_t r;
    r.rst = rst; r.pcw = pcw; r.ctl = ctl; r.op = op;
    r.e_pc = ep; r.e_inst = ei;
    return r;
  endfunction

  initial begin
    Reset = 1'b0; PCWrite = 1'b0; PCControl = 3'd0; RStackOP = 2'd0;

    // Directed sequence: count, hold, push, count, pop-load, count
    tbl.push_back(v(0, 1, 4, 1, 16'd0, 16'd0));
    tbl.push_back(v(1, 1, 4, 0, 16'd2, 16'd0));
    tbl.push_back(v(1, 1, 4, 0, 16'd4, 16'd1));
    for (int i = 0; i < 4; i++) tbl.push_back(v(1, 0, 4, 0, 16'd4, 16'd2));
    tbl.push_back(v(1, 0, 4, 1, 16'd4, 16'd2));
    tbl.push_back(v(1, 1, 4, 0, 16'd6, 16'd2));
    tbl.push_back(v(1, 1, 4, 0, 16'd8, 16'd3));
    tbl.push_back(v(1, 1, 4, 0, 16'd10, 16'd4));
    tbl.push_back(v(1, 1, 4, 0, 16'd12, 16'd5));
    tbl.push_back(v(1, 0, 0, 0, 16'd12, 16'd6));
    tbl.push_back(v(1, 1, 0, 3, 16'd6, 16'd6));
    for (int i = 0; i < 5; i++) tbl.push_back(v(1, 0, 4, 0, 16'd6, 16'd3));
    tbl.push_back(v(1, 1, 4, 0, 16'd8, 16'd3));
    tbl.push_back(v(1, 1, 4, 0, 16'd10, 16'd4));
    tbl.push_back(v(1, 1, 4, 0, 16'd12, 16'd5));
    tbl.push_back(v(1, 1, 4, 0, 16'd14, 16'd6));
    tbl.push_back(v(1, 1, 4, 0, 16'd16, 16'd7));
    // Stack now empty: load from top must give 0
    tbl.push_back(v(1, 1, 0, 0, 16'd0, 16'd8));
    // Multi-cycle reset discards a pending pop/load
    tbl.push_back(v(0, 1, 4, 1, 16'd0, 16'd0));
    tbl.push_back(v(0, 1, 0, 3, 16'd0, 16'd0));
    tbl.push_back(v(1, 1, 0, 0, 16'd0, 16'd0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].pcw, tbl[i].ctl, tbl[i].op);
      chk($sformatf("tbl_pc[%0d]", i), PC_out, tbl[i].e_pc);
      chk($sformatf("tbl_inst[%0d]", i), inst, tbl[i].e_inst);
    end

    // ROM sweep: 20 words after reset
    step(0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 4, 0);
      chk($sformatf("rom_word[%0d]", k), inst,
          (k <= 11) ? k : (k - 11) << 12);
    end

    // Full stack: 17 pushes, the 17th is dropped
    step(0, 0, 0, 0);
    for (int k = 0; k < 17; k++) step(1, 1, 4, 1);
    step(1, 1, 0, 3);
    chk("full_top", PC_out, 16'd32);
    step(1, 1, 0, 3);
    chk("full_next", PC_out, 16'd30);

    // Pop on empty ignored, later push still lands
    step(0, 0, 0, 0);
    step(1, 0, 0, 3);
    step(1, 1, 4, 3);
    step(1, 0, 0, 1);
    step(1, 1, 0, 0);
    chk("empty_pop_push", PC_out, 16'd4);

    // Overflow at PC 0xFFFE, wrap to 0
    step(0, 0, 0, 0);
    for (int k = 0; k < 32767; k++) step(1, 1, 4, 0);
    chk("pc_top", PC_out, 16'hFFFE);
    chk("ovf_set", Overflow, 1);
    step(1, 1, 4, 0);
    chk("pc_wrap", PC_out, 16'h0000);
    chk("ovf_clr", Overflow, 0);

    // Random traffic vs model
    for (int k = 0; k < 4000; k++) begin
      logic [2:0] c;
      c = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7))
        : (($urandom_range(0, 1) == 0) ? 3'd0 : 3'd4);
      step(($urandom_range(0, 60) != 0), 1'($urandom),
           c, 2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/integration_updating_pc.md
INTEGRATION_UPDATING_PC -- requirements
Module: integration_updating_pc

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: synchronous, active-low reset (asserted when 0, sampled on CLK rising edge).
REQ-003 SHALL have port PCWrite, input, 1 bit: PC load enable.
REQ-004 SHALL have port PCControl, input, 3 bits: next-PC source select.
REQ-005 SHALL have port RStackOP, input, 2 bits: return-stack operation (0 hold, 1 push, 2 hold, 3 pop).
REQ-006 SHALL have port Overflow, output, 1 bit: carry-out of the PC+2 adder.
REQ-007 SHALL have port PC_out, output, 16 bits: current PC register value.
REQ-008 SHALL have port inst, output, 16 bits: registered instruction word.
REQ-009 SHALL have parameter RS_DEPTH, default 16: return-stack entries, 16 bits each.
REQ-010 SHALL have parameter IMEM_WORDS, default 512: instruction ROM depth, 16-bit words.

Function
REQ-011 SHALL compute PCplus2 = PC + 2 combinationally, modulo 2^16; Overflow = carry-out of that sum (1 only when PC >= 0xFFFE).
REQ-012 SHALL select next-PC: PCControl=0 -> current return-stack top; PCControl=4 -> PCplus2; any other code -> current PC (hold).
REQ-013 SHALL load PC with next-PC on a rising edge when PCWrite=1; PC SHALL hold when PCWrite=0.
REQ-014 SHALL drive PC_out directly from the PC register.
REQ-015 SHALL implement a LIFO return stack of RS_DEPTH entries with a top pointer; RStackOP=1 pushes PCplus2 (from pre-edge PC) on the rising edge.
REQ-016 RStackOP=3 SHALL pop the stack on the rising edge; RStackOP=0 or 2 SHALL leave it unchanged.
REQ-017 Stack top SHALL read 0 when empty.
REQ-018 Push when full and pop when empty SHALL be ignored; stack contents and pointer unchanged.
REQ-019 When PCWrite=1, PCControl=0 and RStackOP=3 on the same edge, PC SHALL load the pre-pop top value and the stack SHALL pop in that edge.
REQ-020 Push and PC update on the same edge SHALL both use the pre-edge PC.
REQ-021 SHALL hold a read-only instruction ROM of IMEM_WORDS 16-bit words, indexed by PC[9:1] (byte-addressed PC, word-aligned; PC[0] ignored).
REQ-022 ROM contents SHALL be fixed: word k = k for k=0..11; word 11+j = j<<12 for j=1..8 (words 12..19 = 0x1000..0x8000); all other words 0.
REQ-023 SHALL register inst every rising edge (regardless of PCWrite) from ROM[pre-edge PC[9:1]]; inst thus lags PC by one cycle.

Reset
REQ-024 With Reset=0 at a rising edge: PC=0, inst=0, stack emptied (pointer cleared); all other inputs ignored on that edge.
REQ-025 Reset held low for multiple cycles SHALL keep all state at reset values; first edge with Reset=1 resumes normal operation.
REQ-026 Reset asserted mid-operation SHALL discard pending push/pop/PC load on that edge.

Verification
REQ-027 Reset, then PCWrite=1, PCControl=4 -> PC_out 0, 2, 4 on successive cycles; PCWrite=0 for 4 cycles -> PC_out stays 4.
REQ-028 PC=4, RStackOP=1 one cycle (PCWrite=0) -> stack top 6; PCWrite=1, PCControl=4 four cycles -> PC_out 12; PCControl=0, PCWrite=0 -> PC_out stays 12.
REQ-029 PCWrite=1, PCControl=0, RStackOP=3 one cycle -> PC_out 6, stack empty; then PCWrite=0 five cycles -> 6; PCWrite=1, PCControl=4 five cycles -> 16.
REQ-030 Reset, then PCWrite=1, PCControl=4 -> inst sequence 0,1,...,11 then 0x1000,0x2000,...,0x8000 on 20 consecutive cycles.
REQ-031 Pop on empty stack and 17 pushes into a 16-deep stack -> extra operations ignored, top unchanged; PC=0xFFFE -> Overflow=1, next PC 0.
